// File: rtl/seven_seg_scan_decoder.sv
// Receiver for a multiplexed seven-segment scan bus: rebuilds the four displayed
// hex digits, pulses on each complete frame, flags bad anode patterns and scan loss.
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [3:0]  digit_ok,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        anode_err,
    output logic        scan_lost
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_MAX   = CNT_W'(TIMEOUT_CYCLES);

    logic [3:0]        an_reg, an_prev_reg;
    logic [6:0]        seg_reg, seg_prev_reg;
    logic              dp_reg, dp_prev_reg;
    logic              sample_vld_reg;
    logic [STAB_W-1:0] stab_reg, stab_next;
    logic              captured_reg, captured_hold;
    logic [3:0]        seen_reg, seen_base, seen_next;
    logic [3:0]        nib_reg [4];
    logic [3:0]        ok_reg, dp_lit_reg;
    logic              frame_valid_reg, anode_err_reg;
    logic [CNT_W-1:0]  to_cnt_reg;

    logic       an_onehot, an_blank, an_bad, same, cap, frame_done;
    logic [3:0] glyph_nib;
    logic       glyph_ok;

    // Sample register resets to zero, so treat it as blank until the first real sample lands.
    always_comb begin
        an_onehot = 1'b0;
        case (an_reg)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_onehot = sample_vld_reg;
            default:                            an_onehot = 1'b0;
        endcase
        an_blank = !sample_vld_reg || (an_reg == 4'b1111);
        an_bad   = !an_blank && !an_onehot;
        same     = an_onehot &&
                   ({an_reg, seg_reg, dp_reg} == {an_prev_reg, seg_prev_reg, dp_prev_reg});

        stab_next     = '0;
        captured_hold = 1'b0;
        if (same) begin
            stab_next     = (stab_reg == STAB_MAX) ? stab_reg : stab_reg + 1'b1;
            captured_hold = captured_reg;
        end
        cap = an_onehot && (stab_next == STAB_MAX) && !captured_hold;

        seen_base  = clr ? 4'b0000 : seen_reg;
        seen_next  = cap ? (seen_base | ~an_reg) : seen_base;
        frame_done = cap && (seen_next == 4'b1111);
    end

    always_comb begin
        glyph_nib = 4'h0;
        glyph_ok  = 1'b1;
        case (seg_reg)
            7'b1000000: glyph_nib = 4'h0;
            7'b1111001: glyph_nib = 4'h1;
            7'b0100100: glyph_nib = 4'h2;
            7'b0110000: glyph_nib = 4'h3;
            7'b0011001: glyph_nib = 4'h4;
            7'b0010010: glyph_nib = 4'h5;
            7'b0000010: glyph_nib = 4'h6;
            7'b1111000: glyph_nib = 4'h7;
            7'b0000000: glyph_nib = 4'h8;
            7'b0010000: glyph_nib = 4'h9;
            7'b0001000: glyph_nib = 4'hA;
            7'b0000011: glyph_nib = 4'hB;
            7'b1000110: glyph_nib = 4'hC;
            7'b0100001: glyph_nib = 4'hD;
            7'b0000110: glyph_nib = 4'hE;
            7'b0001110: glyph_nib = 4'hF;
            default:    glyph_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_reg          <= '0;
            seg_reg         <= '0;
            dp_reg          <= 1'b0;
            an_prev_reg     <= '0;
            seg_prev_reg    <= '0;
            dp_prev_reg     <= 1'b0;
            sample_vld_reg  <= 1'b0;
            stab_reg        <= '0;
            captured_reg    <= 1'b0;
            seen_reg        <= '0;
            ok_reg          <= '0;
            dp_lit_reg      <= '0;
            frame_valid_reg <= 1'b0;
            anode_err_reg   <= 1'b0;
            to_cnt_reg      <= '0;
            for (int i = 0; i < 4; i++) nib_reg[i] <= '0;
        end else begin
            an_reg         <= an;
            seg_reg        <= seg;
            dp_reg         <= dp;
            an_prev_reg    <= an_reg;
            seg_prev_reg   <= seg_reg;
            dp_prev_reg    <= dp_reg;
            sample_vld_reg <= 1'b1;

            stab_reg        <= stab_next;
            captured_reg    <= captured_hold | cap;
            seen_reg        <= frame_done ? 4'b0000 : seen_next;
            frame_valid_reg <= frame_done;

            for (int i = 0; i < 4; i++) begin
                if (cap && !an_reg[i]) begin
                    nib_reg[i]    <= glyph_nib;
                    ok_reg[i]     <= glyph_ok;
                    dp_lit_reg[i] <= !dp_reg;
                end
            end

            // An error sample on the same edge as clr keeps the flag set.
            if (an_bad)
                anode_err_reg <= 1'b1;
            else if (clr)
                anode_err_reg <= 1'b0;

            if (frame_valid_reg)
                to_cnt_reg <= '0;
            else if (to_cnt_reg != TO_MAX)
                to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digits[4*gi +: 4] = nib_reg[gi];
        end
    endgenerate

    assign digit_ok    = ok_reg;
    assign dp_out      = dp_lit_reg;
    assign frame_valid = frame_valid_reg;
    assign anode_err   = anode_err_reg;
    assign scan_lost   = (to_cnt_reg == TO_MAX);

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receiving end of the multiplexed seven-segment scan interface.
- Monitors the time-multiplexed anode/cathode drive lines and reconstructs the four displayed digits as hex nibbles.
- Flags complete scan frames, malformed anode patterns and loss of scanning.
- Used for loopback self-check of the display path and for readback of display contents to software.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (min 1).
- TIMEOUT_CYCLES, 1000000: cycles without a completed frame before scan_lost asserts.
- CNT_W, 20: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous active-low reset.
- an, input, 4: anode enables, active-low; bit i selects digit i.
- seg, input, 7: cathodes {g,f,e,d,c,b,a}, active-low.
- dp, input, 1: decimal point cathode, active-low.
- clr, input, 1: synchronous clear of anode_err and the frame-progress mask.
- digits, output, 16: decoded nibbles; digit i occupies [4i+3:4i].
- digit_ok, output, 4: bit i high when digit i's last captured pattern was a legal hex glyph.
- dp_out, output, 4: bit i high when digit i's decimal point was lit (dp low) at capture.
- frame_valid, output, 1: one-cycle pulse when all four digits have been captured since the last frame.
- anode_err, output, 1: sticky; an was neither 4'b1111 nor one-hot-low.
- scan_lost, output, 1: high while no frame has completed for TIMEOUT_CYCLES cycles.

Behaviour:
- Reset (rst low, async): digits=0, digit_ok=0, dp_out=0, frame_valid=0, anode_err=0, scan_lost=0. Sample regs, stability counter, captured flag, seen mask and timeout counter all cleared.
- Input stage: an, seg and dp are registered once each cycle; all decisions use the registered sample. Inputs are same-clock-domain, so no synchroniser is required.
- Anode classification of the sample:
  - 1111 = blank: stability counter=0, captured=0, no error.
  - One-hot-low (1110, 1101, 1011, 0111) = valid digit select.
  - Anything else = error: anode_err set, stability counter=0, captured=0.
- Stability:
  - If the sample {an, seg, dp} equals the previous sample and an is valid, the counter increments, saturating at STABLE_CYCLES-1.
  - Otherwise the counter resets to 0 and captured clears.
  - The capture edge is the edge at which the counter is STABLE_CYCLES-1 and captured=0. Total latency from the input change is 1 + STABLE_CYCLES edges.
- Capture, on the capture edge:
  - Write digit i's nibble, digit_ok[i] and dp_out[i]; set seen[i]; set captured=1.
  - Only one capture per dwell; the next capture requires an anode change or a pattern change.
  - Recapturing an already-seen digit overwrites it; seen is unchanged.
- Glyph decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern: nibble=0, digit_ok[i]=0.
- Frame completion:
  - If the capture makes seen==1111, then on that same edge seen clears and frame_valid is registered high.
  - frame_valid is therefore high for exactly the one cycle in which the updated digits first become visible.
- Timeout:
  - The counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - scan_lost=1 while counter==TIMEOUT_CYCLES.
  - A frame_valid edge resets the counter to 0 and drops scan_lost on the following edge.
- clr:
  - Clears anode_err and seen; digits and the timeout counter are unaffected.
  - If clr coincides with an error sample, the set wins and anode_err stays 1.
- Reset mid-dwell or mid-frame discards partial progress; no frame_valid follows without four fresh captures.
- Anode order is not enforced: any sequence covering all four digits completes a frame.

Test Plan:
- Reset check: assert rst low mid-operation -> all outputs 0 immediately (async); deassert -> outputs stay 0 until captures occur.
- Normal scan: STABLE_CYCLES=4; drive an=1110/seg=0110000, then 1101/0010010, 1011/1111000, 0111/0001110, each for 10 cycles -> digits=16'hF753, digit_ok=1111, exactly one frame_valid pulse, arriving 5 edges after the fourth dwell starts.
- Glitch rejection: a 2-cycle dwell on an=1110 between valid dwells -> no capture of digit 0, seen[0] stays 0, no frame_valid.
- Bad anode: drive an=1100 for 1 cycle -> anode_err=1 and stays 1; pulse clr with no error -> anode_err=0; clr on the same cycle as an=0000 -> anode_err stays 1.
- Illegal glyph and decimal point: digit 2 with seg=1111111, dp=0 -> digits[11:8]=0, digit_ok[2]=0, dp_out[2]=1.
- Timeout: TIMEOUT_CYCLES=100, an held at 1111 -> scan_lost=1 from cycle 100 onward; a full scan then gives frame_valid, and scan_lost=0 one cycle later.
